iorq_wr_fsm: RTL and testbench

- Write-side counterpart of the IO read detector. Watches asynchronous Z8S180 IORQ/WR strobes and the address bus on the phi domain.
- For each external IO write that hits the configured port window, it latches address and data, emits a one-phi-cycle wr_tick and holds the value for a downstream consumer.
- It stalls the CPU via wait_req if the consumer has not yet taken the previous write.
- Sits between the CPU bus pins and FPGA peripheral registers.

---
 rtl/iorq_wr_fsm.sv | 171 +++++++++++++++++
 tb/tb_iorq_wr_fsm.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iorq_wr_fsm.sv
// iorq_wr_fsm
//   Captures Z8S180 external IO writes that hit a configurable port window and
//   hands them to a phi-domain consumer. The CPU gets a WAIT request when a new
//   write arrives before the consumer has taken the previous one.
//
// Parameters
//   ADDR  IO port base address, compared against a[7:0]
//   MASK  compare mask; a 1 bit takes part in the address compare
//
// Ports
//   phi       in   CPU clock; all state changes on the rising edge
//   reset     in   asynchronous active-low reset
//   iorq      in   IORQ strobe, positive logic, asynchronous to phi
//   wr        in   WR strobe, positive logic, asynchronous to phi
//   a[7:0]    in   low IO address, stable while iorq=1
//   d[7:0]    in   data bus, stable around the WR pulse
//   wr_ack    in   consumer takes the pending write (sampled on phi rise)
//   wr_tick   out  one-phi-cycle pulse per captured write
//   wr_valid  out  a captured write is pending for the consumer
//   wr_addr   out  captured address
//   wr_data   out  captured data
//   wait_req  out  CPU WAIT request, positive logic
module iorq_wr_fsm #(
  parameter logic [7:0] ADDR = 8'h00,
  parameter logic [7:0] MASK = 8'hFF
) (
  input  logic       phi,
  input  logic       reset,
  input  logic       iorq,
  input  logic       wr,
  input  logic [7:0] a,
  input  logic [7:0] d,
  input  logic       wr_ack,
  output logic       wr_tick,
  output logic       wr_valid,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       wait_req
);

  typedef enum logic [1:0] {
    ARM   = 2'd0,
    IDLE  = 2'd1,
    STALL = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic       s1_reg, s2_reg;
  logic       primed_reg;
  logic       tick_reg, tick_next;
  logic       valid_reg, valid_next;
  logic       wait_reg, wait_next;
  logic [7:0] addr_reg, addr_next;
  logic [7:0] data_reg, data_next;
  logic       capture;
  logic       req;
  logic       hit;

  // A write request is IORQ and WR together; a read never qualifies.
  assign req = iorq & wr;
  assign hit = ((a ^ ADDR) & MASK) == 8'h00;

  // Two-flop synchronizer for the asynchronous request. primed_reg marks that
  // the synchronizer has clocked at least once since reset, so the cleared
  // reset values of s1/s2 are not mistaken for a genuinely idle bus.
  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      s1_reg     <= 1'b0;
      s2_reg     <= 1'b0;
      primed_reg <= 1'b0;
    end else begin
      s1_reg     <= req;
      s2_reg     <= s1_reg;
      primed_reg <= 1'b1;
    end
  end

  always_ff @(posedge phi or negedge reset) begin
    if (!reset) begin
      state_reg <= ARM;
      tick_reg  <= 1'b0;
      valid_reg <= 1'b0;
      wait_reg  <= 1'b0;
      addr_reg  <= 8'h00;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      tick_reg  <= tick_next;
      valid_reg <= valid_next;
      wait_reg  <= wait_next;
      addr_reg  <= addr_next;
      data_reg  <= data_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    wait_next  = wait_reg;
    capture    = 1'b0;

    case (state_reg)
      // Leaving reset in the middle of a bus cycle must not capture it: wait
      // until the synchronizer has filled and reports the request gone.
      ARM: begin
        if (primed_reg && !s1_reg && !s2_reg) begin
          state_next = IDLE;
        end
      end

      IDLE: begin
        if (s2_reg) begin
          if (!hit) begin
            state_next = HOLD;
          end else if (!valid_reg || wr_ack) begin
            capture    = 1'b1;
            state_next = HOLD;
          end else begin
            wait_next  = 1'b1;
            state_next = STALL;
          end
        end
      end

      // The CPU is held in wait states, so the bus stays stable until the
      // consumer frees the holding register.
      STALL: begin
        if (wr_ack) begin
          capture    = 1'b1;
          wait_next  = 1'b0;
          state_next = HOLD;
        end
      end

      // One capture per CPU cycle: re-arm only once the request has dropped.
      HOLD: begin
        if (!s2_reg) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = ARM;
      end
    endcase
  end

  // Capture wins over a same-edge acknowledge: the new write replaces the
  // one just taken and stays pending.
  always_comb begin
    tick_next  = 1'b0;
    valid_next = valid_reg;
    addr_next  = addr_reg;
    data_next  = data_reg;
    if (capture) begin
      tick_next  = 1'b1;
      valid_next = 1'b1;
      addr_next  = a;
      data_next  = d;
    end else if (wr_ack) begin
      valid_next = 1'b0;
    end
  end

  assign wr_tick  = tick_reg;
  assign wr_valid = valid_reg;
  assign wr_addr  = addr_reg;
  assign wr_data  = data_reg;
  assign wait_req = wait_reg;

endmodule

// File: tb/tb_iorq_wr_fsm.sv
// tb_iorq_wr_fsm
//   Directed bench for iorq_wr_fsm with the port window at 8'h40 / 8'hFF.
//   Inputs change 1 ns after a rising phi edge; outputs are sampled there too.
module tb_iorq_wr_fsm;

  logic       phi;
  logic       reset;
  logic       iorq;
  logic       wr;
  logic [7:0] a;
  logic [7:0] d;
  logic       wr_ack;
  logic       wr_tick;
  logic       wr_valid;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       wait_req;

  int checks = 0;
  int errors = 0;
  int ticks;
  int first;
  int waits;

  iorq_wr_fsm #(
    .ADDR(8'h40),
    .MASK(8'hFF)
  ) dut (
    .phi      (phi),
    .reset    (reset),
    .iorq     (iorq),
    .wr       (wr),
    .a        (a),
    .d        (d),
    .wr_ack   (wr_ack),
    .wr_tick  (wr_tick),
    .wr_valid (wr_valid),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wait_req (wait_req)
  );

  initial phi = 1'b0;
  always #15 phi = ~phi;

  task automatic step();
    @(posedge phi);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full write cycle held for 'hold' phi edges, then 4 idle edges.
  // Reports tick count, the edge index of the first tick and wait_req edges.
  task automatic write_cycle(input logic [7:0] addr, input logic [7:0] data,
                             input int hold, output int n_tick,
                             output int first_tick, output int n_wait);
    n_tick = 0;
    first_tick = 0;
    n_wait = 0;
    a = addr;
    d = data;
    iorq = 1'b1;
    wr = 1'b1;
    for (int i = 1; i <= hold; i++) begin
      step();
      if (wr_tick) begin
        n_tick++;
        if (first_tick == 0) first_tick = i;
      end
      if (wait_req) n_wait++;
    end
    iorq = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wr_tick) n_tick++;
      if (wait_req) n_wait++;
    end
    $display("write a=%0h d=%0h ticks=%0d first=%0d waits=%0d", addr, data, n_tick, first_tick, n_wait);
  endtask

  task automatic ack_pulse();
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    iorq = 1'b0;
    wr = 1'b0;
    a = 8'h00;
    d = 8'h00;
    wr_ack = 1'b0;

    // 1. reset, then a quiet bus
    #1 reset = 1'b0;
    #20;
    chk("rst_tick", wr_tick, 0);
    chk("rst_valid", wr_valid, 0);
    chk("rst_wait", wait_req, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_data", wr_data, 0);
    #30 reset = 1'b1;
    ticks = 0;
    waits = 0;
    for (int i = 0; i < 17; i++) begin
      step();
      if (wr_tick) ticks++;
      if (wait_req || wr_valid) waits++;
    end
    chk("idle_ticks", ticks, 0);
    chk("idle_flags", waits, 0);
    $display("idle after reset: ticks=%0d", ticks);

    // 2. hit write 40/A5, then acknowledge
    write_cycle(8'h40, 8'hA5, 6, ticks, first, waits);
    chk("w1_ticks", ticks, 1);
    chk("w1_first_edge", first, 3);
    chk("w1_waits", waits, 0);
    chk("w1_addr", wr_addr, 8'h40);
    chk("w1_data", wr_data, 8'hA5);
    chk("w1_valid", wr_valid, 1);
    ack_pulse();
    chk("w1_ack_valid", wr_valid, 0);
    chk("w1_ack_addr_hold", wr_addr, 8'h40);

    // 3. miss write to 41, then a read of 40
    write_cycle(8'h41, 8'h5C, 6, ticks, first, waits);
    chk("miss_ticks", ticks, 0);
    chk("miss_valid", wr_valid, 0);
    chk("miss_waits", waits, 0);
    chk("miss_data_hold", wr_data, 8'hA5);
    a = 8'h40;
    d = 8'h99;
    iorq = 1'b1;
    wr = 1'b0;
    ticks = 0;
    waits = 0;
    for (int i = 0; i < 10; i++) begin
      if (i == 6) iorq = 1'b0;
      step();
      if (wr_tick) ticks++;
      if (wait_req) waits++;
    end
    chk("read_ticks", ticks, 0);
    chk("read_waits", waits, 0);
    chk("read_valid", wr_valid, 0);
    $display("io read a=40: ticks=%0d", ticks);

    // 4. overrun: 40/11 left pending, then 40/22 stalls until ack
    write_cycle(8'h40, 8'h11, 6, ticks, first, waits);
    chk("ov1_ticks", ticks, 1);
    chk("ov1_data", wr_data, 8'h11);
    chk("ov1_valid", wr_valid, 1);
    a = 8'h40;
    d = 8'h22;
    iorq = 1'b1;
    wr = 1'b1;
    step();
    step();
    chk("ov2_wait_pre", wait_req, 0);
    step();
    chk("ov2_wait_set", wait_req, 1);
    chk("ov2_no_tick", wr_tick, 0);
    chk("ov2_data_old", wr_data, 8'h11);
    step();
    chk("ov2_wait_hold", wait_req, 1);
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    chk("ov2_wait_clr", wait_req, 0);
    chk("ov2_tick", wr_tick, 1);
    chk("ov2_data", wr_data, 8'h22);
    chk("ov2_valid", wr_valid, 1);
    step();
    chk("ov2_tick_one", wr_tick, 0);
    iorq = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("ov2_valid_after", wr_valid, 1);
    $display("overrun 40/22: data=%0h valid=%0b", wr_data, wr_valid);

    // 5. ack lands on the capture edge of 40/33
    a = 8'h40;
    d = 8'h33;
    iorq = 1'b1;
    wr = 1'b1;
    step();
    step();
    wr_ack = 1'b1;
    step();
    wr_ack = 1'b0;
    chk("sim_tick", wr_tick, 1);
    chk("sim_valid", wr_valid, 1);
    chk("sim_data", wr_data, 8'h33);
    chk("sim_wait", wait_req, 0);
    step();
    step();
    chk("sim_wait_later", wait_req, 0);
    iorq = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk("sim_valid_after", wr_valid, 1);
    ack_pulse();
    chk("sim_ack_valid", wr_valid, 0);
    ack_pulse();
    chk("spurious_ack_valid", wr_valid, 0);
    chk("spurious_ack_data", wr_data, 8'h33);
    $display("simultaneous ack/capture 40/33: data=%0h", wr_data);

    // 6. reset during a write, released while iorq/wr still high
    a = 8'h40;
    d = 8'h77;
    iorq = 1'b1;
    wr = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #5 reset = 1'b0;
    #1;
    chk("mid_rst_valid", wr_valid, 0);
    chk("mid_rst_data", wr_data, 0);
    chk("mid_rst_wait", wait_req, 0);
    #30 reset = 1'b1;
    ticks = 0;
    waits = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (wr_tick) ticks++;
      if (wait_req || wr_valid) waits++;
    end
    chk("mid_rel_ticks", ticks, 0);
    chk("mid_rel_flags", waits, 0);
    chk("mid_rel_data", wr_data, 0);
    iorq = 1'b0;
    wr = 1'b0;
    for (int i = 0; i < 4; i++) step();
    write_cycle(8'h40, 8'h5A, 6, ticks, first, waits);
    chk("post_rst_ticks", ticks, 1);
    chk("post_rst_first", first, 3);
    chk("post_rst_addr", wr_addr, 8'h40);
    chk("post_rst_data", wr_data, 8'h5A);
    chk("post_rst_valid", wr_valid, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
